// File: rtl/mem_cache_if.sv
// Bundles the MEM-stage request bus and the SRAM-controller bus of the data cache.
//
// Handshake rules:
//   - CPU side: rd_en/wr_en act as request valids. pause is the inverse of ready.
//     A request completes on a cycle where it is asserted and pause=0.
//     The pipeline holds rd_en, wr_en, addr and wdata stable while pause=1.
//   - SRAM side: sram_rd_en/sram_wr_en are request valids. They are held, together
//     with sram_addr/sram_wdata, until a cycle where sram_ready=1.
//     sram_ready is a one-cycle completion pulse, and sram_rdata is valid only in
//     that cycle. The request drops on the following cycle.
interface mem_cache_if #(
  parameter int LINE_WORDS = 2
);
  logic                    rd_en;
  logic                    wr_en;
  logic [31:0]             addr;
  logic [31:0]             wdata;
  logic [31:0]             rdata;
  logic                    pause;
  logic                    flush;
  logic                    sram_rd_en;
  logic                    sram_wr_en;
  logic [31:0]             sram_addr;
  logic [31:0]             sram_wdata;
  logic [32*LINE_WORDS-1:0] sram_rdata;
  logic                    sram_ready;
  logic [31:0]             hit_cnt;
  logic [31:0]             miss_cnt;

  modport slave (
    input  rd_en, wr_en, addr, wdata, flush, sram_rdata, sram_ready,
    output rdata, pause, sram_rd_en, sram_wr_en, sram_addr, sram_wdata, hit_cnt, miss_cnt
  );

  modport master (
    output rd_en, wr_en, addr, wdata, flush, sram_rdata, sram_ready,
    input  rdata, pause, sram_rd_en, sram_wr_en, sram_addr, sram_wdata, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/mem_cache_ctrl.sv
// N-way set-associative, write-through, no-write-allocate data cache controller
// for the MEM stage. Read hits return in the same cycle. Read misses fill a whole
// line from SRAM with round-robin replacement. Writes always go through to SRAM.
module mem_cache_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'd1024,
  parameter int          WAYS       = 2,
  parameter int          SETS       = 64,
  parameter int          LINE_WORDS = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_cache_if.slave       mem_if,
  output logic [1:0]       dbg_state_o
);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int OFF_SW = (OFF_W > 0) ? OFF_W : 1;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_SH = 2 + OFF_W + IDX_W;
  localparam int TAG_W  = 32 - TAG_SH;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = 32 * LINE_WORDS;
  localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2} state_t;

  state_t             state_q;
  logic [SETS-1:0]    valid_q [WAYS];
  logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
  logic [LINE_W-1:0]  data_q  [WAYS][SETS];
  logic [WAY_W-1:0]   ptr_q   [SETS];
  logic               flush_pend_q;
  logic [IDX_W-1:0]   fill_idx_q;
  logic [TAG_W-1:0]   fill_tag_q;
  logic [OFF_SW-1:0]  fill_off_q;
  logic               sram_rd_en_q;
  logic               sram_wr_en_q;
  logic [31:0]        sram_addr_q;
  logic [31:0]        sram_wdata_q;
  logic [31:0]        hit_cnt_q;
  logic [31:0]        miss_cnt_q;

  logic [31:0]        ea;
  logic [OFF_SW-1:0]  off;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [LINE_W-1:0]  hit_line;
  logic [31:0]        hit_word;
  logic [31:0]        fill_word;
  logic [WAY_W-1:0]   victim;
  logic               fill_done;
  logic               pause_c;
  logic [31:0]        rdata_c;

  // Address decode relative to the start of the data region.
  assign ea  = mem_if.addr - BASE_ADDR;
  assign off = ea[2 +: OFF_SW] & OFF_SW'(LINE_WORDS - 1);
  assign idx = ea[TAG_SH-1 -: IDX_W];
  assign tag = ea[31 -: TAG_W];

  // Tag compare across every way of the indexed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_line  = data_q[hit_way][idx];
  assign hit_word  = hit_line[32*off +: 32];
  assign fill_word = mem_if.sram_rdata[32*fill_off_q +: 32];
  assign victim    = (WAYS > 1) ? ptr_q[fill_idx_q] : '0;
  assign fill_done = (state_q == FILL) && mem_if.sram_ready;

  // Stall and load-data generation; a completing fill bypasses its word straight to rdata.
  always_comb begin
    pause_c = 1'b0;
    rdata_c = '0;
    case (state_q)
      IDLE: begin
        if (mem_if.wr_en) begin
          pause_c = 1'b1;
        end else if (mem_if.rd_en) begin
          if (hit) rdata_c = hit_word;
          else     pause_c = 1'b1;
        end
      end
      FILL: begin
        pause_c = !mem_if.sram_ready;
        if (mem_if.sram_ready) rdata_c = fill_word;
      end
      WRITE:   pause_c = !mem_if.sram_ready;
      default: pause_c = 1'b0;
    endcase
  end

  // Controller FSM: valid bits, victim pointers, SRAM requests and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
      flush_pend_q <= 1'b0;
      fill_idx_q   <= '0;
      fill_tag_q   <= '0;
      fill_off_q   <= '0;
      sram_rd_en_q <= 1'b0;
      sram_wr_en_q <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // The request this cycle was already judged against pre-flush tags.
          if (mem_if.flush) begin
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
          end
          if (mem_if.wr_en) begin
            state_q      <= WRITE;
            sram_wr_en_q <= 1'b1;
            sram_addr_q  <= ea & ~32'h3;
            sram_wdata_q <= mem_if.wdata;
          end else if (mem_if.rd_en) begin
            if (hit) begin
              if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
              if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
              state_q      <= FILL;
              sram_rd_en_q <= 1'b1;
              sram_addr_q  <= ea & ~LINE_MASK;
              fill_idx_q   <= idx;
              fill_tag_q   <= tag;
              fill_off_q   <= off;
            end
          end
        end
        FILL: begin
          if (mem_if.flush) flush_pend_q <= 1'b1;
          if (mem_if.sram_ready) begin
            valid_q[victim][fill_idx_q] <= 1'b1;
            if (WAYS > 1) ptr_q[fill_idx_q] <= ptr_q[fill_idx_q] + WAY_W'(1);
            sram_rd_en_q <= 1'b0;
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            // A flush seen during the fill wins over the freshly written line.
            if (flush_pend_q || mem_if.flush) begin
              for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            end
          end
        end
        WRITE: begin
          if (mem_if.flush) flush_pend_q <= 1'b1;
          if (mem_if.sram_ready) begin
            sram_wr_en_q <= 1'b0;
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            if (flush_pend_q || mem_if.flush) begin
              for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line and tag storage: fills write a whole line, write hits patch one word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_done) begin
        data_q[victim][fill_idx_q] <= mem_if.sram_rdata;
        tag_q[victim][fill_idx_q]  <= fill_tag_q;
      end
      if ((state_q == IDLE) && mem_if.wr_en && hit) begin
        data_q[hit_way][idx][32*off +: 32] <= mem_if.wdata;
      end
    end
  end

  assign mem_if.rdata      = rdata_c;
  assign mem_if.pause      = pause_c;
  assign mem_if.sram_rd_en = sram_rd_en_q;
  assign mem_if.sram_wr_en = sram_wr_en_q;
  assign mem_if.sram_addr  = sram_addr_q;
  assign mem_if.sram_wdata = sram_wdata_q;
  assign mem_if.hit_cnt    = hit_cnt_q;
  assign mem_if.miss_cnt   = miss_cnt_q;
  assign dbg_state_o       = state_q;
endmodule
